// File: rtl/vec_issue_pkg.sv
// vec_issue_pkg
// Shared types and constants for the vector issue/sequencing controller.
//   issue_state_e : FSM state encoding
//   OP_*          : execution-unit operation codes
//   SEW*_OH       : one-hot SEW/EEW selects for the execution unit
package vec_issue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MUL_ARM  = 3'd2,
        ST_MUL_WAIT = 3'd3,
        ST_WB       = 3'd4
    } issue_state_e;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SHIFT = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_IDLE  = 3'b111;

    localparam logic [6:0] SEW8_OH  = 7'b0001000;
    localparam logic [6:0] SEW16_OH = 7'b0010000;
    localparam logic [6:0] SEW32_OH = 7'b0100000;

endpackage

// File: rtl/vec_issue_perf_cnt.sv
// vec_issue_perf_cnt
// Free-running 32-bit performance counters for the issue controller.
// Both counters wrap naturally at 2^32.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   op_done    : one completed writeback handshake this cycle
//   busy       : controller is not idle this cycle
//   perf_ops   : count of completed operations
//   perf_busy  : count of non-idle cycles
module vec_issue_perf_cnt
    import vec_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_done,
    input  logic        busy,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_busy
);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (op_done) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (busy) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end

endmodule

// File: rtl/vector_processor_defs.svh
// vector_processor_defs.svh
// Shared width macros for the vector processor datapath.
// MAX_VLEN is the widest vector register, in bits, that any unit handles.
`ifndef VECTOR_PROCESSOR_DEFS_SVH
`define VECTOR_PROCESSOR_DEFS_SVH

`define MAX_VLEN 128

`endif

// File: rtl/vec_exec_issue_ctrl.sv
// vec_exec_issue_ctrl
// Issue/sequencing controller between vector decode and register-file
// writeback. Accepts one decoded op, holds it stable on the execution-unit
// inputs for one cycle (add) or until the multiplier reports done (mul, with
// a timeout), then presents the captured result to writeback.
// Optional feature macro: VEC_ISSUE_PERF_EN (builds the perf counters;
// otherwise perf_ops/perf_busy are tied to 0).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   issue_*                         : decode handshake and operation fields
//   eu_* (out)                      : execution-unit operands and controls
//   eu_result, eu_count_0 (in)      : execution-unit result and mul done
//   wb_valid/wb_ready, wb_data,
//   wb_vd, wb_err                   : writeback handshake and payload
//   perf_ops, perf_busy             : performance counters
`include "vector_processor_defs.svh"

module vec_exec_issue_ctrl
    import vec_issue_pkg::*;
#(
    parameter int VLEN        = `MAX_VLEN,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [2:0]      issue_op,
    input  logic [6:0]      issue_sew,
    input  logic            issue_ctrl,
    input  logic            issue_signed,
    input  logic            issue_mul_low,
    input  logic            issue_mul_high,
    input  logic            issue_rsub,
    input  logic [VLEN-1:0] issue_vs1,
    input  logic [VLEN-1:0] issue_vs2,
    input  logic [4:0]      issue_vd,

    output logic [VLEN-1:0] eu_data_1,
    output logic [VLEN-1:0] eu_data_2,
    output logic            eu_ctrl,
    output logic            eu_signed_mode,
    output logic            eu_mul_low,
    output logic            eu_mul_high,
    output logic            eu_reverse_sub,
    output logic [6:0]      eu_sew_eew,
    output logic [2:0]      eu_execution_op,
    input  logic [VLEN-1:0] eu_result,
    input  logic            eu_count_0,

    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [VLEN-1:0] wb_data,
    output logic [4:0]      wb_vd,
    output logic            wb_err,

    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_busy
);

    // A timeout of 1 still needs a one-bit counter so the compare is legal.
    localparam int CNT_W = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

    issue_state_e state;
    issue_state_e state_next;

    logic [VLEN-1:0]  vs1_q;
    logic [VLEN-1:0]  vs2_q;
    logic [2:0]       op_q;
    logic [6:0]       sew_q;
    logic             ctrl_q;
    logic             signed_q;
    logic             mul_low_q;
    logic             mul_high_q;
    logic             rsub_q;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;
    logic             eu_active;

    assign timeout_hit = (timeout_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MUL_ARM never looks at eu_count_0: a done level left over from the
    // previous multiply would otherwise be taken as this one's result.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (issue_valid) begin
                    case (issue_op)
                        OP_ADD:  state_next = ST_EXEC;
                        OP_MUL:  state_next = ST_MUL_ARM;
                        default: state_next = ST_WB;
                    endcase
                end
            end
            ST_EXEC:     state_next = ST_WB;
            ST_MUL_ARM:  state_next = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (eu_count_0 || timeout_hit) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // issue_ready is masked by reset so it reads 0 during the reset cycle.
    always_comb begin
        issue_ready     = (state == ST_IDLE) && !reset;
        wb_valid        = (state == ST_WB);
        eu_active       = (state == ST_EXEC) || (state == ST_MUL_ARM) ||
                          (state == ST_MUL_WAIT);
        eu_data_1       = '0;
        eu_data_2       = '0;
        eu_ctrl         = 1'b0;
        eu_signed_mode  = 1'b0;
        eu_mul_low      = 1'b0;
        eu_mul_high     = 1'b0;
        eu_reverse_sub  = 1'b0;
        eu_sew_eew      = '0;
        eu_execution_op = OP_IDLE;
        if (eu_active) begin
            eu_data_1       = vs1_q;
            eu_data_2       = vs2_q;
            eu_ctrl         = ctrl_q;
            eu_signed_mode  = signed_q;
            eu_mul_low      = mul_low_q;
            eu_mul_high     = mul_high_q;
            eu_reverse_sub  = rsub_q;
            eu_sew_eew      = sew_q;
            eu_execution_op = op_q;
        end
    end

    // Operand capture on accept, result capture at the end of EXEC or the
    // MUL_WAIT cycle that sees done; a timeout or unsupported op reports 0
    // with the error flag set. A done in the timeout cycle still wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs1_q       <= '0;
            vs2_q       <= '0;
            op_q        <= OP_IDLE;
            sew_q       <= '0;
            ctrl_q      <= 1'b0;
            signed_q    <= 1'b0;
            mul_low_q   <= 1'b0;
            mul_high_q  <= 1'b0;
            rsub_q      <= 1'b0;
            timeout_cnt <= '0;
            wb_data     <= '0;
            wb_vd       <= '0;
            wb_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_valid) begin
                        vs1_q      <= issue_vs1;
                        vs2_q      <= issue_vs2;
                        op_q       <= issue_op;
                        sew_q      <= issue_sew;
                        ctrl_q     <= issue_ctrl;
                        signed_q   <= issue_signed;
                        mul_low_q  <= issue_mul_low;
                        mul_high_q <= issue_mul_high;
                        rsub_q     <= issue_rsub;
                        wb_vd      <= issue_vd;
                        wb_data    <= '0;
                        wb_err     <= !((issue_op == OP_ADD) || (issue_op == OP_MUL));
                    end
                end
                ST_EXEC: begin
                    wb_data <= eu_result;
                end
                ST_MUL_ARM: begin
                    timeout_cnt <= '0;
                end
                ST_MUL_WAIT: begin
                    if (eu_count_0) begin
                        wb_data <= eu_result;
                    end else if (timeout_hit) begin
                        wb_data <= '0;
                        wb_err  <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef VEC_ISSUE_PERF_EN
    logic wb_fire;
    logic fsm_busy;

    assign wb_fire  = wb_valid && wb_ready;
    assign fsm_busy = (state != ST_IDLE);

    vec_issue_perf_cnt u_perf_cnt (
        .clk       (clk),
        .reset     (reset),
        .op_done   (wb_fire),
        .busy      (fsm_busy),
        .perf_ops  (perf_ops),
        .perf_busy (perf_busy)
    );
`else
    assign perf_ops  = '0;
    assign perf_busy = '0;
`endif

endmodule

// File: doc/vec_exec_issue_ctrl.md
# vec_exec_issue_ctrl

Issue/sequencing controller that drives the vector execution unit and collects its results. It accepts one decoded vector arithmetic operation from decode with a valid/ready handshake, holds the operands and controls stable on the execution-unit inputs, and waits the correct number of cycles: one for add/sub, or until the multiplier's `count_0` completion for multiply. It then presents the captured result to writeback with a valid/ready handshake. It sits between vector decode and the vector register-file writeback port.

## Interface
- `VLEN`, default `` `MAX_VLEN ``: operand and result width in bits.
- `MUL_TIMEOUT`, default 64: maximum number of MUL_WAIT cycles before the operation is aborted.
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `issue_valid` / `issue_ready` in/out 1: decode handshake.
- `issue_op` in 3: 000 add, 011 mul; any other value is unsupported.
- `issue_sew` in 7: one-hot SEW/EEW (0001000 = 8, 0010000 = 16, 0100000 = 32).
- `issue_ctrl`, `issue_signed`, `issue_mul_low`, `issue_mul_high`, `issue_rsub` in 1 each: op modifiers.
- `issue_vs1`, `issue_vs2` in VLEN: operands.
- `issue_vd` in 5: destination register.
- `eu_data_1`, `eu_data_2` out VLEN; `eu_ctrl`, `eu_signed_mode`, `eu_mul_low`, `eu_mul_high`, `eu_reverse_sub` out 1; `eu_sew_eew` out 7; `eu_execution_op` out 3: execution-unit controls.
- `eu_result` in VLEN; `eu_count_0` in 1 (multiplier done, level).
- `wb_valid` / `wb_ready` out/in 1: writeback handshake.
- `wb_data` out VLEN; `wb_vd` out 5; `wb_err` out 1.
- `perf_ops` out 32; `perf_busy` out 32: see Configuration.

## Operation
- The FSM has five states: IDLE, EXEC, MUL_ARM, MUL_WAIT, WB.
- IDLE: `issue_ready`=1. On `issue_valid`, all issue fields are registered into the operand registers.
  - op 000 goes to EXEC.
  - op 011 goes to MUL_ARM.
  - Any other op goes directly to WB with `wb_data`=0 and `wb_err`=1.
- While the FSM is in EXEC, MUL_ARM or MUL_WAIT, the `eu_*` outputs are driven from the operand registers and are constant.
- In IDLE and WB, `eu_execution_op`=3'b111, the `eu_data_*` outputs are 0, and all `eu_*` 1-bit controls are 0.
- EXEC lasts one cycle. At the end of it, `eu_result` is captured into `wb_data`, and the FSM goes to WB.
- MUL_ARM lasts one cycle and ignores `eu_count_0`, so that a stale done from the previous multiply is not taken. The FSM then goes to MUL_WAIT and the timeout counter is cleared.
- MUL_WAIT, checked in this priority order:
  - If `eu_count_0`=1: capture `eu_result` and go to WB.
  - Otherwise, if the counter equals MUL_TIMEOUT-1: set `wb_data`=0 and `wb_err`=1, and go to WB.
  - Otherwise: increment the counter.
- WB: `wb_valid`=1, and `wb_data`, `wb_vd` and `wb_err` are held stable. On `wb_ready`, the FSM returns to IDLE. There is no lookahead: `issue_ready` is 0 in WB.
- `wb_vd` always equals the `issue_vd` captured for the operation being reported.

## Timing
- Reset values: FSM in IDLE; `issue_ready`=0 during the reset cycle and 1 after it; `wb_valid`, `wb_err`, `wb_data`, `wb_vd`=0; `eu_execution_op`=3'b111; all other `eu_*` outputs 0; timeout counter 0; perf counters 0.
- Add latency: issue accepted at clock edge E0 gives `wb_valid`=1 in the cycle after edge E1. That is 2 cycles, assuming the combinational `eu_result` settles within EXEC.
- Multiply latency: 2 + N cycles, where N is the number of MUL_WAIT cycles until `eu_count_0` is seen. The minimum is 3.
- Throughput: at most one operation in flight. The best case for add is one operation per 3 cycles, when `wb_ready` is held at 1.
- Reset asserted in any state returns the FSM to IDLE at the next edge. Any in-flight operation is dropped and no writeback is issued for it.
- If `eu_count_0` and the timeout occur in the same cycle, `eu_count_0` wins.
- When `MUL_TIMEOUT`=1, a multiply that is not done in its first MUL_WAIT cycle is aborted.

## Configuration
- Macro: `VEC_ISSUE_PERF_EN`.
- When defined:
  - `perf_ops` increments on every completed WB handshake and wraps at 2^32.
  - `perf_busy` increments on every cycle the FSM is not in IDLE and wraps at 2^32.
- When undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package `vec_issue_pkg` contains:
  - The state enum `issue_state_e`.
  - The op constants OP_ADD=3'b000, OP_SHIFT=3'b001, OP_MUL=3'b011, OP_IDLE=3'b111.
  - The SEW one-hot constants SEW8_OH, SEW16_OH, SEW32_OH.
- Width macros come from `vector_processor_defs.svh`.
- One sub-module, `vec_issue_perf_cnt`, holds the two perf counters. It is instantiated only under `VEC_ISSUE_PERF_EN`.

## Test plan
- Add: op 000, SEW 0100000, lane 0 with vs1=5 and vs2=7, `wb_ready`=1. Required: `wb_valid` rises 2 cycles after accept, `wb_data[31:0]`=12, `wb_err`=0, `wb_vd` equals the issued vd, and `eu_execution_op`=3'b111 in the cycle after the handshake.
- Multiply: op 011, SEW 0100000, `issue_mul_low`=1, lane 0 operands 6 and 9, with `eu_count_0` driven high 10 cycles after accept. Required: `wb_valid` in cycle 11, `wb_data[31:0]`=54, and `eu_*` stable throughout.
- Timeout: `MUL_TIMEOUT`=8 and `eu_count_0` held 0. Required: `wb_valid`=1 with `wb_err`=1 and `wb_data`=0 exactly 10 cycles after accept.
- Backpressure and unsupported op: op 001 issued with `wb_ready`=0 for 5 cycles. Required: WB is entered immediately with `wb_err`=1, `wb_valid` and the data stay stable for the 5 cycles, and `issue_ready`=0 until the handshake completes.
- Reset mid-multiply: assert `reset` in MUL_WAIT. Required: the next cycle shows IDLE, `wb_valid`=0 and `eu_execution_op`=3'b111, and no writeback occurs for the dropped operation.
- Stale done: `eu_count_0` held at 1 across the accept cycle and MUL_ARM. Required: the result is captured in the first MUL_WAIT cycle, not earlier. With `VEC_ISSUE_PERF_EN` defined, `perf_ops` increments by 1.
